// File: rtl/pixie_video_back_end_if.sv
// Framebuffer RAM read port between the video back end (master) and the frame RAM (slave).
interface pixie_video_back_end_if;
    logic [9:0] mem_rd_addr;
    logic [7:0] mem_rd_data;

    modport master (output mem_rd_addr, input mem_rd_data);
    modport slave  (input mem_rd_addr, output mem_rd_data);
endinterface

// File: rtl/pixie_video_back_end.sv
// Pixie framebuffer read side: scans the 1 KB frame RAM into a 1-bit raster with sync and blank
// timing. Every registered output describes the pixel at the pre-tick hcount/vcount.
module pixie_video_back_end #(
    parameter int unsigned H_TOTAL        = 400,
    parameter int unsigned H_ACTIVE       = 256,
    parameter int unsigned H_SYNC_START   = 300,
    parameter int unsigned H_SYNC_LEN     = 32,
    parameter int unsigned V_TOTAL        = 262,
    parameter int unsigned V_ACTIVE       = 128,
    parameter int unsigned V_SYNC_START   = 200,
    parameter int unsigned V_SYNC_LEN     = 3,
    parameter int unsigned BYTES_PER_LINE = 8,
    parameter int unsigned H_SCALE        = 4,
    parameter int unsigned V_SCALE        = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          clk_enable,
    input  logic                          disp_en,
    pixie_video_back_end_if.master        mem,
    output logic                          video,
    output logic                          hsync,
    output logic                          vsync,
    output logic                          hblank,
    output logic                          vblank,
    output logic                          frame_start
);
    localparam int unsigned SCW = (H_SCALE > 1) ? $clog2(H_SCALE) : 1;

    localparam logic [8:0]     H_LAST   = 9'(H_TOTAL - 1);
    localparam logic [8:0]     V_LAST   = 9'(V_TOTAL - 1);
    localparam logic [8:0]     H_ACT    = 9'(H_ACTIVE);
    localparam logic [8:0]     V_ACT    = 9'(V_ACTIVE);
    localparam logic [9:0]     HS_START = 10'(H_SYNC_START);
    localparam logic [9:0]     HS_END   = 10'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [9:0]     VS_START = 10'(V_SYNC_START);
    localparam logic [9:0]     VS_END   = 10'(V_SYNC_START + V_SYNC_LEN);
    localparam logic [SCW-1:0] SC_LAST  = SCW'(H_SCALE - 1);

    logic [8:0]     hcount, vcount, hcount_next, vcount_next, line_next;
    logic [9:0]     rd_addr, base;
    logic [7:0]     shreg, shreg_cur;
    logic [2:0]     bit_idx;
    logic [SCW-1:0] scale_cnt;
    logic           frame_en, h_last, v_last, active, load, msb, addr_setup;
    logic           hsync_hit, vsync_hit;

    assign mem.mem_rd_addr = rd_addr;

    always_comb begin
        h_last      = (hcount == H_LAST);
        v_last      = (vcount == V_LAST);
        hcount_next = h_last ? 9'd0 : hcount + 9'd1;
        line_next   = v_last ? 9'd0 : vcount + 9'd1;
        vcount_next = h_last ? line_next : vcount;
        active      = (hcount < H_ACT) && (vcount < V_ACT);
        load        = active && (bit_idx == 3'd0) && (scale_cnt == '0);
        shreg_cur   = load ? mem.mem_rd_data : shreg;
        msb         = shreg_cur[7];
        // Row base for the line that starts after this tick; V_SCALE lines share one row.
        addr_setup  = h_last && (line_next < V_ACT);
        base        = 10'((32'(line_next) / V_SCALE) * BYTES_PER_LINE);
        hsync_hit   = ({1'b0, hcount} >= HS_START) && ({1'b0, hcount} < HS_END);
        vsync_hit   = ({1'b0, vcount} >= VS_START) && ({1'b0, vcount} < VS_END);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcount      <= 9'd0;
            vcount      <= 9'd0;
            rd_addr     <= 10'd0;
            shreg       <= 8'd0;
            bit_idx     <= 3'd0;
            scale_cnt   <= '0;
            frame_en    <= 1'b0;
            video       <= 1'b0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            hblank      <= 1'b1;
            vblank      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (clk_enable) begin
                hcount      <= hcount_next;
                vcount      <= vcount_next;
                hblank      <= (hcount >= H_ACT);
                vblank      <= (vcount >= V_ACT);
                hsync       <= hsync_hit;
                vsync       <= vsync_hit;
                video       <= frame_en && active && msb;
                frame_start <= (hcount == 9'd0) && (vcount == 9'd0);
                if (h_last && v_last) begin
                    frame_en <= disp_en;
                end
                if (addr_setup) begin
                    rd_addr <= base;
                end else if (load) begin
                    rd_addr <= rd_addr + 10'd1;
                end
                if (active) begin
                    if (scale_cnt == SC_LAST) begin
                        scale_cnt <= '0;
                        bit_idx   <= bit_idx + 3'd1;
                        shreg     <= {shreg_cur[6:0], 1'b0};
                    end else begin
                        scale_cnt <= scale_cnt + SCW'(1);
                        shreg     <= shreg_cur;
                    end
                end
            end
        end
    end
endmodule
